ps2_host_cmd: RTL

Host-to-device command controller for the PS/2 keyboard link. It sequences command transmission (for example set-LEDs 0xED plus an argument byte, or enable 0xF4) onto the open-drain kbclk/kbdata lines. It then waits for the device's 0xFA acknowledge, returned through the existing receive path, and handles 0xFE resend, timeouts and retries. It sits beside the PS/2 receiver and owns line direction while a command is in flight.

---
 rtl/ps2_host_cmd.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/ps2_host_cmd.sv
// PS/2 host-to-device command sequencer: inhibit, request-to-send,
// 11-bit host frame, 0xFA/0xFE response handling with retries.
module ps2_host_cmd #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int MAX_RETRY      = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_byte,
  input  logic       has_arg,
  input  logic [7:0] arg_byte,
  input  logic       kbclk_in,
  input  logic       kbdata_in,
  output logic       kbclk_oe,
  output logic       kbdata_oe,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic       rx_hold,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int CW =
    $clog2(TIMEOUT_CYCLES + INHIBIT_CYCLES + 1);
  localparam int RW = $clog2(MAX_RETRY + 2);

  localparam logic [CW-1:0] INH_PRE =
    CW'(INHIBIT_CYCLES - 2);
  localparam logic [CW-1:0] INH_LAST =
    CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] TMO_LAST =
    CW'(TIMEOUT_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_MAX =
    RW'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_REQ,
    S_TX,
    S_WAIT,
    S_FAIL
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [RW-1:0]   retry;
  logic [3:0]      bitn;
  logic [7:0]      cur_byte;
  logic [7:0]      arg_q;
  logic [7:0]      sh;
  logic            arg_pending;

  logic            k1, k2, kp;
  logic            d1, d2;
  logic            fe;
  logic            odd_par;

  // Lines idle high, so the synchronizer resets to 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k1 <= 1'b1;
      k2 <= 1'b1;
      kp <= 1'b1;
      d1 <= 1'b1;
      d2 <= 1'b1;
    end else begin
      k1 <= kbclk_in;
      k2 <= k1;
      kp <= k2;
      d1 <= kbdata_in;
      d2 <= d1;
    end
  end

  assign fe      = kp & ~k2;
  assign odd_par = ~^cur_byte;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      kbclk_oe    <= 1'b0;
      kbdata_oe   <= 1'b0;
      cmd_ready   <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      rx_hold     <= 1'b0;
      cnt         <= '0;
      retry       <= '0;
      bitn        <= '0;
      cur_byte    <= '0;
      arg_q       <= '0;
      sh          <= '0;
      arg_pending <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            cur_byte    <= cmd_byte;
            arg_q       <= arg_byte;
            arg_pending <= has_arg;
            retry       <= '0;
            cnt         <= '0;
            kbclk_oe    <= 1'b1;
            rx_hold     <= 1'b1;
            busy        <= 1'b1;
            cmd_ready   <= 1'b0;
            state       <= S_INHIBIT;
          end
        end
        S_INHIBIT: begin
          cnt <= cnt + 1'b1;
          if (cnt == INH_PRE)
            kbdata_oe <= 1'b1;
          if (cnt == INH_LAST) begin
            kbclk_oe <= 1'b0;
            state    <= S_REQ;
          end
        end
        S_REQ: begin
          kbdata_oe <= 1'b1;
          bitn      <= '0;
          cnt       <= '0;
          sh        <= cur_byte;
          state     <= S_TX;
        end
        S_TX: begin
          if (cnt == TMO_LAST) begin
            kbclk_oe  <= 1'b0;
            kbdata_oe <= 1'b0;
            state     <= S_FAIL;
          end else begin
            cnt <= cnt + 1'b1;
            if (fe) begin
              bitn <= bitn + 1'b1;
              unique case (1'b1)
                (bitn < 4'd8): begin
                  kbdata_oe <= ~sh[0];
                  sh        <= {1'b0, sh[7:1]};
                end
                (bitn == 4'd8):
                  kbdata_oe <= ~odd_par;
                (bitn == 4'd9):
                  kbdata_oe <= 1'b0;
                default: begin
                  // Device acks by holding data low.
                  if (!d2) begin
                    rx_hold <= 1'b0;
                    cnt     <= '0;
                    state   <= S_WAIT;
                  end else begin
                    kbdata_oe <= 1'b0;
                    state     <= S_FAIL;
                  end
                end
              endcase
            end
          end
        end
        S_WAIT: begin
          if (cnt == TMO_LAST) begin
            kbclk_oe  <= 1'b0;
            kbdata_oe <= 1'b0;
            state     <= S_FAIL;
          end else begin
            cnt <= cnt + 1'b1;
            if (rx_valid && rx_data == 8'hFA) begin
              if (arg_pending) begin
                cur_byte    <= arg_q;
                arg_pending <= 1'b0;
                retry       <= '0;
                cnt         <= '0;
                kbclk_oe    <= 1'b1;
                rx_hold     <= 1'b1;
                state       <= S_INHIBIT;
              end else begin
                done      <= 1'b1;
                busy      <= 1'b0;
                cmd_ready <= 1'b1;
                state     <= S_IDLE;
              end
            end else if (rx_valid &&
                         rx_data == 8'hFE) begin
              kbclk_oe  <= 1'b0;
              kbdata_oe <= 1'b0;
              state     <= S_FAIL;
            end
          end
        end
        S_FAIL: begin
          kbclk_oe  <= 1'b0;
          kbdata_oe <= 1'b0;
          if (retry < RETRY_MAX) begin
            retry    <= retry + 1'b1;
            cnt      <= '0;
            kbclk_oe <= 1'b1;
            rx_hold  <= 1'b1;
            state    <= S_INHIBIT;
          end else begin
            err       <= 1'b1;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
            rx_hold   <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
